// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - four-digit multiplexed hex display scanner with frame-synchronous value commit
module seven_seg_scanner #(
    parameter int TICK_BITS = 18
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        pending
);

    logic [TICK_BITS-1:0] prescale;
    logic                 tick;
    logic                 wrap;
    logic [1:0]           idx;
    logic [1:0]           idx_next;
    logic [15:0]          shown;
    logic [15:0]          shown_next;
    logic [3:0]           shown_dp;
    logic [3:0]           shown_dp_next;
    logic [15:0]          pend_val;
    logic [3:0]           pend_dp;
    logic [3:0]           nibble;
    logic                 blank;
    logic [6:0]           seg_next;
    logic                 dp_next;

    // A digit advances when the prescaler reaches all-ones; the 3->0 advance is the frame wrap.
    assign tick     = &prescale;
    assign wrap     = tick && (idx == 2'd3);
    assign idx_next = idx + 2'd1;

    // Free-running prescaler.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) prescale <= '0;
        else       prescale <= prescale + {{(TICK_BITS-1){1'b0}}, 1'b1};
    end

    // Digit index advances once per tick.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset)     idx <= 2'd0;
        else if (tick) idx <= idx_next;
    end

    // The value the display will show after this edge; commits only land on a frame wrap.
    always_comb begin
        shown_next    = shown;
        shown_dp_next = shown_dp;
        if (wrap && pending) begin
            shown_next    = pend_val;
            shown_dp_next = pend_dp;
        end
    end

    // Displayed value, pending load register and its flag; a load on the wrap edge re-arms pending.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            shown    <= '0;
            shown_dp <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pending  <= 1'b0;
        end else begin
            shown    <= shown_next;
            shown_dp <= shown_dp_next;
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end else if (wrap) begin
                pending  <= 1'b0;
            end
        end
    end

    // Segment pattern for the digit being selected on this edge, using the post-commit value.
    always_comb begin
        nibble = shown_next[{idx_next, 2'b00} +: 4];
        case (idx_next)
            2'd1:    blank = blank_lz && (shown_next[15:4]  == 12'h000) && !shown_dp_next[1];
            2'd2:    blank = blank_lz && (shown_next[15:8]  == 8'h00)   && !shown_dp_next[2];
            2'd3:    blank = blank_lz && (shown_next[15:12] == 4'h0)    && !shown_dp_next[3];
            default: blank = 1'b0;
        endcase
        case (nibble)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h03;
            4'hC: seg_next = 7'h46;
            4'hD: seg_next = 7'h21;
            4'hE: seg_next = 7'h06;
            default: seg_next = 7'h0E;
        endcase
        dp_next = ~shown_dp_next[idx_next];
        if (blank) begin
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end
    end

    // Registered display drive, refreshed together with the digit index.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            an  <= 4'b1110;
            seg <= 7'h40;
            dp  <= 1'b1;
        end else if (tick) begin
            an  <= ~(4'b0001 << idx_next);
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

    // One-cycle pulse after every frame wrap.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= wrap;
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner with a cycle model
module tb_seven_seg_scanner;

    localparam int TB  = 2;
    localparam int TOP = (1 << TB) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        pending;

    int n_total = 0;
    int n_pass  = 0;

    seven_seg_scanner #(.TICK_BITS(TB)) dut (
        .clock_100Mhz(clk),
        .reset(reset),
        .value(value),
        .dp_in(dp_in),
        .load(load),
        .blank_lz(blank_lz),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_done(frame_done),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: cycle count within the digit slot, digit position, displayed and pending words.
    logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_cnt   = 0;
    int          m_idx   = 0;
    logic [15:0] m_shown = 16'h0;
    logic [3:0]  m_sdp   = 4'h0;
    logic [15:0] m_pv    = 16'h0;
    logic [3:0]  m_pdp   = 4'h0;
    logic        m_pend  = 1'b0;
    logic        m_fd    = 1'b0;
    logic [3:0]  m_an    = 4'b1110;
    logic [6:0]  m_seg   = 7'h40;
    logic        m_dp    = 1'b1;

    // Digit k is dark when everything from digit k upward is zero and it has no decimal point.
    function automatic logic is_blank(input logic [15:0] w, input logic [3:0] pts, input int k, input logic en);
        return en && (k != 0) && ((w >> (4 * k)) == 16'h0) && !pts[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_shown = 0; m_sdp = 0; m_pv = 0; m_pdp = 0;
            m_pend = 0; m_fd = 0; m_an = 4'b1110; m_seg = 7'h40; m_dp = 1'b1;
        end else begin
            m_fd = 1'b0;
            if (m_cnt == TOP) begin
                if (m_idx == 3) begin
                    m_fd = 1'b1;
                    if (m_pend) begin
                        m_shown = m_pv;
                        m_sdp   = m_pdp;
                        m_pend  = 1'b0;
                    end
                end
                m_idx = (m_idx + 1) % 4;
                m_an  = 4'hF & ~(4'h1 << m_idx);
                if (is_blank(m_shown, m_sdp, m_idx, blank_lz)) begin
                    m_seg = 7'h7F;
                    m_dp  = 1'b1;
                end else begin
                    m_seg = hex_lut[(m_shown / (16 ** m_idx)) % 16];
                    m_dp  = !m_sdp[m_idx];
                end
            end
            m_cnt = (m_cnt + 1) % (TOP + 1);
            if (load) begin
                m_pv   = value;
                m_pdp  = dp_in;
                m_pend = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        check("an",         {12'h0, an},         {12'h0, m_an});
        check("seg",        {9'h0, seg},         {9'h0, m_seg});
        check("dp",         {15'h0, dp},         {15'h0, m_dp});
        check("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
        check("pending",    {15'h0, pending},    {15'h0, m_pend});
    end

    task automatic wait_pos(input int i, input int c);
        for (int n = 0; n < 200; n++) begin
            if (m_idx == i && m_cnt == c) return;
            @(negedge clk);
        end
        n_total++;
        $display("FAIL wait_pos: idx/cnt %0d/%0d not reached, required %0d/%0d", m_idx, m_cnt, i, c);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Walk to just after the next wrap, then visit each digit slot and check literal patterns.
    task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                               input logic [6:0] e3, input logic [3:0] edp);
        logic [6:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        wait_pos(3, TOP);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            wait_pos(k, 0);
            check($sformatf("lit_an%0d", k),  {12'h0, an},  {12'h0, 4'hF & ~(4'h1 << k)});
            check($sformatf("lit_seg%0d", k), {9'h0, seg},  {9'h0, e[k]});
            check($sformatf("lit_dp%0d", k),  {15'h0, dp},  {15'h0, edp[k]});
        end
    endtask

    int fd_count;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_an",  {12'h0, an},  16'h000E);
        check("rst_seg", {9'h0, seg},  16'h0040);
        check("rst_dp",  {15'h0, dp},  16'h0001);
        check("rst_pending", {15'h0, pending}, 16'h0000);
        reset = 1'b0;

        // Idle scan: exactly one frame_done in 16 clocks.
        fd_count = 0;
        repeat (16) begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
        check("fd_count_16", fd_count[15:0], 16'd1);

        // Load mid-frame, commit at wrap.
        wait_pos(1, 0);
        do_load(16'h1A3F, 4'b0100);
        check("pending_set", {15'h0, pending}, 16'h0001);
        check_frame(7'h0E, 7'h30, 7'h08, 7'h79, 4'b1011);
        check("pending_clr", {15'h0, pending}, 16'h0000);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0005, 4'b0000);
        check_frame(7'h12, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        do_load(16'h0000, 4'b0000);
        check_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
        blank_lz = 1'b0;

        // Two loads in one frame: last wins.
        wait_pos(0, 1);
        do_load(16'h1111, 4'b0000);
        @(negedge clk);
        do_load(16'h2222, 4'b0000);
        check_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'b1111);

        // Load coinciding with the wrap tick.
        wait_pos(0, 0);
        do_load(16'h1111, 4'b0000);
        wait_pos(3, TOP);
        do_load(16'h3333, 4'b0000);
        check("simul_seg0", {9'h0, seg}, 16'h0079);
        check("simul_pending", {15'h0, pending}, 16'h0001);
        check_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'b1111);
        check("simul_pending_clr", {15'h0, pending}, 16'h0000);

        // Reset mid-frame with a pending load.
        wait_pos(1, 1);
        do_load(16'h8888, 4'b0001);
        check("pre_rst_pending", {15'h0, pending}, 16'h0001);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_an",  {12'h0, an},  16'h000E);
        check("mid_rst_seg", {9'h0, seg},  16'h0040);
        check("mid_rst_dp",  {15'h0, dp},  16'h0001);
        check("mid_rst_pending", {15'h0, pending}, 16'h0000);
        check("mid_rst_fd",  {15'h0, frame_done}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
